// File: rtl/sr_latch_bank.sv
// rtl/sr_latch_bank.sv - bank of N registered set/reset latches with conflict rule, edge pulses and optional auto-clear timer
module sr_latch_bank #(
  parameter int N       = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] tmo
);

  logic [N-1:0] base_q;
  logic [N-1:0] expire;
  logic [N-1:0] q_nxt;

  always_comb begin
    base_q = q;
    for (int i = 0; i < N; i++) begin
      case ({s[i], r[i]})
        2'b10:   base_q[i] = 1'b1;
        2'b01:   base_q[i] = 1'b0;
        2'b11: begin
          case (MODE)
            0:       base_q[i] = 1'b0;
            1:       base_q[i] = 1'b1;
            2:       base_q[i] = q[i];
            default: base_q[i] = ~q[i];
          endcase
        end
        default: base_q[i] = q[i];
      endcase
    end
  end

  // Expiry beats r and the conflict rule; clr beats everything, including expiry.
  assign q_nxt = clr ? '0 : (base_q & ~expire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      rise <= '0;
      fall <= '0;
      tmo  <= '0;
    end else begin
      q    <= q_nxt;
      rise <= q_nxt & ~q;
      fall <= q & ~q_nxt;
      tmo  <= clr ? '0 : expire;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt [N];

      // cnt counts edges since the channel was last armed; expiry when it reaches TIMEOUT-1.
      always_comb begin
        expire = '0;
        for (int i = 0; i < N; i++) begin
          expire[i] = q[i] & ~s[i] & (cnt[i] == CW'(TIMEOUT - 1));
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (clr || !q_nxt[i] || !q[i] || s[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] != {CW{1'b1}}) begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end
    end else begin : g_no_timer
      assign expire = '0;
    end
  endgenerate

endmodule

// File: tb/tb_sr_latch_bank.sv
// tb/tb_sr_latch_bank.sv - checks four MODE variants of sr_latch_bank against a timestamp-based reference model
module tb_sr_latch_bank;

  localparam int N = 4;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic [N-1:0] q    [4];
  logic [N-1:0] rise [4];
  logic [N-1:0] fall [4];
  logic [N-1:0] tmo  [4];

  int checks   = 0;
  int failures = 0;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_latch_bank #(.N(N), .MODE(m), .TIMEOUT(T)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .s    (s),
      .r    (r),
      .q    (q[m]),
      .rise (rise[m]),
      .fall (fall[m]),
      .tmo  (tmo[m])
    );
  end

  always #5 clk = ~clk;

  // Reference: each channel remembers the edge number at which it was last armed.
  bit mq [4][N];
  bit er [4][N];
  bit ef [4][N];
  bit et [4][N];
  int arm [4][N];
  int cyc = 0;

  task automatic model_reset();
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < N; i++) begin
        mq[m][i] = 0; er[m][i] = 0; ef[m][i] = 0; et[m][i] = 0; arm[m][i] = 0;
      end
  endtask

  task automatic model_edge();
    cyc++;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < N; i++) begin
        bit old, nq, to;
        old = mq[m][i];
        to  = 0;
        if (clr) nq = 0;
        else if (old && !s[i] && (cyc - arm[m][i] == T)) begin nq = 0; to = 1; end
        else if (s[i] && r[i]) nq = (m == 0) ? 1'b0 : (m == 1) ? 1'b1 : (m == 2) ? old : !old;
        else if (s[i]) nq = 1;
        else if (r[i]) nq = 0;
        else nq = old;
        if (nq && (!old || s[i])) arm[m][i] = cyc;
        er[m][i] = nq & !old;
        ef[m][i] = old & !nq;
        et[m][i] = to;
        mq[m][i] = nq;
      end
  endtask

  task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int m = 0; m < 4; m++) begin
      logic [N-1:0] eq, erv, efv, etv;
      for (int i = 0; i < N; i++) begin
        eq[i] = mq[m][i]; erv[i] = er[m][i]; efv[i] = ef[m][i]; etv[i] = et[m][i];
      end
      chk($sformatf("%s.m%0d.q", tag, m), q[m], eq);
      chk($sformatf("%s.m%0d.rise", tag, m), rise[m], erv);
      chk($sformatf("%s.m%0d.fall", tag, m), fall[m], efv);
      chk($sformatf("%s.m%0d.tmo", tag, m), tmo[m], etv);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(string tag);
    #3 rst = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 4; m++) chk($sformatf("%s.m%0d.q_now", tag, m), q[m], 4'b0000);
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; s = '0; r = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all("reset");
    rst = 1'b0;

    // basic set / clear
    s = 4'b0001; tick("set");
    chk("basic.q", q[0], 4'b0001);
    chk("basic.rise", rise[0], 4'b0001);
    s = 4'b0000; tick("set_hold");
    chk("basic.rise_once", rise[0], 4'b0000);
    r = 4'b0001; tick("clear");
    chk("basic.fall", fall[0], 4'b0001);
    r = 4'b0000; tick("idle");

    // conflict per mode from q=0101
    s = 4'b0101; tick("pre_conflict");
    s = 4'b1111; r = 4'b1111; tick("conflict");
    chk("conflict.m0", q[0], 4'b0000);
    chk("conflict.m1", q[1], 4'b1111);
    chk("conflict.m2", q[2], 4'b0101);
    chk("conflict.m3", q[3], 4'b1010);
    s = '0; r = '0; clr = 1'b1; tick("clr1");
    clr = 1'b0; tick("idle2");

    // plain timeout
    s = 4'b0001; tick("to_set");
    s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick("to_run");
      chk("timeout.held", q[0], 4'b0001);
    end
    tick("to_expire");
    chk("timeout.q", q[0], 4'b0000);
    chk("timeout.fall", fall[0], 4'b0001);
    chk("timeout.tmo", tmo[0], 4'b0001);
    tick("to_after");

    // retrigger on the expiry edge
    s = 4'b0001; tick("rt_set");
    s = 4'b0000;
    repeat (4) tick("rt_run");
    s = 4'b0001; tick("rt_race");
    chk("retrig.q", q[0], 4'b0001);
    chk("retrig.tmo", tmo[0], 4'b0000);
    s = 4'b0000;
    repeat (4) tick("rt_run2");
    tick("rt_expire");
    chk("retrig.tmo_late", tmo[0], 4'b0001);
    tick("rt_after");

    // clr beats set
    s = 4'b0011; tick("clr_pre");
    s = 4'b1111; clr = 1'b1; tick("clr_vs_set");
    chk("clr.q", q[0], 4'b0000);
    chk("clr.fall", fall[0], 4'b0011);
    chk("clr.tmo", tmo[0], 4'b0000);
    s = '0; clr = 1'b0; tick("clr_after");

    // async reset mid-count
    s = 4'b0001; tick("ar_set");
    s = 4'b0000;
    repeat (2) tick("ar_run");
    async_reset("ar_pulse");
    repeat (6) tick("ar_quiet");
    chk("areset.no_tmo", tmo[0], 4'b0000);
    s = 4'b0001; tick("ar_reuse");
    chk("areset.rise", rise[0], 4'b0001);
    s = 4'b0000; tick("ar_done");

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      s   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      r   = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 79) == 0) begin
        @(posedge clk);
        model_edge();
        async_reset("rnd_rst");
      end else begin
        tick("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
